// File: rtl/input_dispatch_pkg.sv
// Shared types, field layout and header validation for the input dispatcher.
package input_dispatch_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 9;
  localparam int unsigned PKT_CNT_W  = 16;
  localparam int unsigned HDR_ID_LSB = 0;
  localparam int unsigned HDR_ID_W   = 2;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2
  } state_t;

  // A header is valid when every bit above the id field is zero and the id names an existing unit.
  function automatic logic header_ok(input logic [BYTE_W-1:0] h,
                                     input int unsigned n_units,
                                     input int unsigned id_w);
    int unsigned v;
    v = 32'(h) >> HDR_ID_LSB;
    return ((v >> id_w) == 32'd0) && ((v & ((32'd1 << id_w) - 32'd1)) < n_units);
  endfunction

endpackage

// File: rtl/input_dispatch.sv
// Parses header/length/payload packets from an external FWFT FIFO and steers the payload to one unit.
module input_dispatch
  import input_dispatch_pkg::*;
#(
  parameter int unsigned N_UNITS   = 4,
  parameter int unsigned UNIT_ID_W = HDR_ID_W
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [BYTE_W-1:0]    fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic                 dispatch_en,
  output logic [BYTE_W-1:0]    unit_din,
  output logic [N_UNITS-1:0]   unit_wr_en,
  input  logic [N_UNITS-1:0]   unit_full,
  output logic                 busy,
  output logic [PKT_CNT_W-1:0] pkt_count,
  output logic                 err
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [UNIT_ID_W-1:0] sel_q, sel_d;
  int unsigned          sel_idx;
  logic                 sel_full;
  logic                 err_set;
  logic                 pkt_done;

  assign sel_idx  = 32'(sel_q);
  assign unit_din = fifo_dout;
  // Outputs are gated by reset so nothing moves while the registers are being cleared.
  assign busy     = RST_N && (state_q != HDR);

  // Full flag of the currently selected unit.
  always_comb begin
    sel_full = 1'b0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      if (sel_idx == i) sel_full = unit_full[i];
    end
  end

  // Next-state, pop strobe and write strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    fifo_rd_en = 1'b0;
    unit_wr_en = '0;
    err_set    = 1'b0;
    pkt_done   = 1'b0;
    case (state_q)
      HDR: begin
        if (!fifo_empty && dispatch_en) begin
          fifo_rd_en = 1'b1;
          if (header_ok(fifo_dout, N_UNITS, UNIT_ID_W)) begin
            sel_d   = fifo_dout[HDR_ID_LSB +: UNIT_ID_W];
            state_d = LEN;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      LEN: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          cnt_d      = (fifo_dout == '0) ? CNT_W'(256) : CNT_W'(fifo_dout);
          state_d    = DATA;
        end
      end
      DATA: begin
        if (!fifo_empty && !sel_full) begin
          fifo_rd_en = 1'b1;
          for (int unsigned i = 0; i < N_UNITS; i++) begin
            unit_wr_en[i] = (sel_idx == i);
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = HDR;
            pkt_done = 1'b1;
          end
        end
      end
      default: state_d = HDR;
    endcase
    if (!RST_N) begin
      fifo_rd_en = 1'b0;
      unit_wr_en = '0;
    end
  end

  // State, counters and sticky error with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= HDR;
      cnt_q     <= '0;
      sel_q     <= '0;
      pkt_count <= '0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      if (pkt_done) pkt_count <= pkt_count + PKT_CNT_W'(1);
      if (err_set) err <= 1'b1;
    end
  end

endmodule
